dcache_fsm_nway: RTL and testbench

Main control FSM for the next-generation L1 D-cache: N-way set-associative with a multi-beat line refill, write-through stores and strongly-ordered uncached (SUC) accesses. Sits between the pipeline memory stage, request buffer, TagV/Data arrays, replacement logic and the L2/AXI bridge. Generalises the 2-way single-beat controller to any power-of-two way count and line size, and adds an optional hit/miss performance counter pair.

---
 rtl/dcache_fsm_nway.sv | 202 ++++++++++++++++++++
 tb/tb_dcache_fsm_nway.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_fsm_nway.sv
// Main control FSM for an N-way set-associative L1 D-cache with multi-beat refill.
// Optional hit/miss performance counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_fsm_nway #(
  parameter int index_width  = 4,
  parameter int offset_width = 4,
  parameter int way          = 4,
  localparam int WB    = $clog2(way),
  localparam int BW    = ((offset_width - 2) > 1) ? (offset_width - 2) : 1,
  localparam int BEATS = 1 << (offset_width - 2)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            pipeline_dcache_valid,
  input  logic            pipeline_dcache_opflag,
  output logic            dcache_pipeline_ready,
  output logic            dcache_pipeline_stall,
  output logic            ack_op,
  output logic            dcache_mem_req,
  output logic            dcache_mem_wr,
  input  logic            mem_dcache_addrOK,
  input  logic            mem_dcache_dataOK,
  output logic            FSM_rbuf_we,
  input  logic [31:0]     FSM_rbuf_opcode,
  input  logic [31:0]     FSM_rbuf_addr,
  input  logic            FSM_rbuf_type,
  input  logic            FSM_rbuf_SUC,
  input  logic [way-1:0]  FSM_hit,
  input  logic [way-1:0]  FSM_victim,
  output logic [way-1:0]  FSM_use,
  output logic [way-1:0]  FSM_Data_we,
  output logic [way-1:0]  FSM_TagV_we,
  output logic [way-1:0]  FSM_TagV_unvalid,
  output logic [way-1:0]  FSM_TagV_init,
  output logic            FSM_Data_replace,
  output logic [BW-1:0]   FSM_refill_beat,
  output logic [WB-1:0]   FSM_choose_way,
  output logic            FSM_choose_return,
  output logic [31:0]     perf_hit_cnt,
  output logic [31:0]     perf_miss_cnt
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WR_WAIT, RD_REQ, RD_DATA, RD_DONE, OPERATION
  } state_t;

  localparam int unused_index_width = index_width;

  state_t          state, state_next;
  logic [BW-1:0]   beat_cnt, beat_cnt_next;
  logic [WB-1:0]   hit_idx;
  logic [way-1:0]  hit_oh, addr_oh;
  logic            any_hit, miss, last_beat, accept;
  logic [BW-1:0]   word_idx;
  logic            unused_bits;

  assign unused_bits = ^{FSM_rbuf_opcode, FSM_rbuf_addr};

  // Lowest-index hitting way wins when several ways report a hit.
  always_comb begin
    hit_idx = '0;
    for (int i = way - 1; i >= 0; i--) begin
      if (FSM_hit[i]) hit_idx = WB'(i);
    end
  end

  assign any_hit   = |FSM_hit;
  assign miss      = ~any_hit | FSM_rbuf_SUC;
  assign hit_oh    = way'(1) << hit_idx;
  assign addr_oh   = way'(1) << FSM_rbuf_addr[WB-1:0];
  assign word_idx  = FSM_rbuf_addr[offset_width-1:2];
  assign last_beat = FSM_rbuf_SUC | (beat_cnt == BW'(BEATS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next            = state;
    beat_cnt_next         = beat_cnt;
    accept                = 1'b0;
    dcache_pipeline_ready = 1'b0;
    FSM_rbuf_we           = 1'b0;
    ack_op                = 1'b0;
    dcache_mem_req        = 1'b0;
    dcache_mem_wr         = 1'b0;
    FSM_use               = '0;
    FSM_Data_we           = '0;
    FSM_TagV_unvalid      = '0;
    FSM_TagV_init         = '0;
    FSM_Data_replace      = 1'b0;
    FSM_refill_beat       = '0;
    FSM_choose_way        = '0;
    FSM_choose_return     = 1'b0;

    case (state)
      IDLE: accept = 1'b1;

      LOOKUP: begin
        if (FSM_rbuf_SUC && any_hit) FSM_TagV_unvalid = hit_oh;
        if (FSM_rbuf_type) begin
          dcache_mem_req = 1'b1;
          dcache_mem_wr  = 1'b1;
          if (!miss) begin
            FSM_Data_we = hit_oh;
            FSM_use     = hit_oh;
          end
          if (mem_dcache_addrOK) accept = 1'b1;
          else                   state_next = WR_WAIT;
        end else if (!miss) begin
          FSM_choose_way = hit_idx;
          FSM_use        = hit_oh;
          accept         = 1'b1;
        end else begin
          dcache_mem_req = 1'b1;
          beat_cnt_next  = '0;
          state_next     = mem_dcache_addrOK ? RD_DATA : RD_REQ;
        end
      end

      WR_WAIT: begin
        dcache_mem_req = 1'b1;
        dcache_mem_wr  = 1'b1;
        if (mem_dcache_addrOK) accept = 1'b1;
      end

      RD_REQ: begin
        dcache_mem_req = 1'b1;
        beat_cnt_next  = '0;
        if (mem_dcache_addrOK) state_next = RD_DATA;
      end

      // addrOK is deliberately ignored here; only returning beats advance the refill.
      RD_DATA: begin
        dcache_mem_req  = 1'b1;
        FSM_refill_beat = beat_cnt;
        if (mem_dcache_dataOK) begin
          FSM_Data_replace  = 1'b1;
          if (!FSM_rbuf_SUC) FSM_Data_we = FSM_victim;
          FSM_choose_return = FSM_rbuf_SUC | (beat_cnt == word_idx);
          beat_cnt_next     = beat_cnt + BW'(1);
          if (last_beat) begin
            if (!FSM_rbuf_SUC) FSM_use = FSM_victim;
            state_next = RD_DONE;
          end
        end
      end

      RD_DONE: accept = 1'b1;

      OPERATION: begin
        ack_op = 1'b1;
        accept = 1'b1;
        case (FSM_rbuf_opcode[4:3])
          2'd0:    FSM_TagV_init    = addr_oh;
          2'd1:    FSM_TagV_unvalid = addr_oh;
          2'd2:    if (any_hit) FSM_TagV_unvalid = hit_oh;
          default: ;
        endcase
      end

      default: state_next = IDLE;
    endcase

    if (accept) begin
      dcache_pipeline_ready = 1'b1;
      FSM_rbuf_we           = 1'b1;
      state_next = pipeline_dcache_valid ?
                   (pipeline_dcache_opflag ? OPERATION : LOOKUP) : IDLE;
    end
  end

  assign FSM_TagV_we           = FSM_Data_we;
  assign dcache_pipeline_stall = ~dcache_pipeline_ready;

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;

  // SUC accesses count as neither a hit nor a cached miss.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (!miss)                      hit_cnt  <= hit_cnt + 32'd1;
      if (!any_hit && !FSM_rbuf_SUC)  miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign perf_hit_cnt  = hit_cnt;
  assign perf_miss_cnt = miss_cnt;
`else
  assign perf_hit_cnt  = '0;
  assign perf_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_fsm_nway.sv
// Transaction-level randomized bench for dcache_fsm_nway (way=4, 4 refill beats).
// Expected outputs come from each request's own properties, not from a copy of the FSM.
module tb_dcache_fsm_nway;

`ifdef DCACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid, opflag, ready, stall, ack_op, mem_req, mem_wr;
  logic        addr_ok, data_ok, rbuf_we;
  logic [31:0] rbuf_opcode, rbuf_addr;
  logic        rbuf_type, rbuf_suc;
  logic [3:0]  hit, victim, use_o, data_we, tagv_we, tagv_unvalid, tagv_init;
  logic        data_replace, choose_return;
  logic [1:0]  refill_beat, choose_way;
  logic [31:0] perf_hit, perf_miss;

  dcache_fsm_nway dut (
    .clk(clk), .rstn(rstn),
    .pipeline_dcache_valid(valid), .pipeline_dcache_opflag(opflag),
    .dcache_pipeline_ready(ready), .dcache_pipeline_stall(stall), .ack_op(ack_op),
    .dcache_mem_req(mem_req), .dcache_mem_wr(mem_wr),
    .mem_dcache_addrOK(addr_ok), .mem_dcache_dataOK(data_ok),
    .FSM_rbuf_we(rbuf_we), .FSM_rbuf_opcode(rbuf_opcode), .FSM_rbuf_addr(rbuf_addr),
    .FSM_rbuf_type(rbuf_type), .FSM_rbuf_SUC(rbuf_suc),
    .FSM_hit(hit), .FSM_victim(victim), .FSM_use(use_o),
    .FSM_Data_we(data_we), .FSM_TagV_we(tagv_we),
    .FSM_TagV_unvalid(tagv_unvalid), .FSM_TagV_init(tagv_init),
    .FSM_Data_replace(data_replace), .FSM_refill_beat(refill_beat),
    .FSM_choose_way(choose_way), .FSM_choose_return(choose_return),
    .perf_hit_cnt(perf_hit), .perf_miss_cnt(perf_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_op;
    logic [1:0] op;
    logic [31:0] addr;
    bit         wr;
    bit         suc;
    logic [3:0] hit;
    logic [3:0] victim;
    int         delay;
    int         rst_beat;
  } req_t;

  req_t   directed[$];
  req_t   cur, nxt;
  bit     offered, need_idle;
  int     checks = 0, errors = 0;
  int     exp_hits = 0, exp_misses = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.is_op    = ($urandom_range(0, 4) == 0);
    r.op       = 2'($urandom_range(0, 3));
    r.addr     = $urandom;
    r.wr       = ($urandom_range(0, 2) == 0);
    r.suc      = ($urandom_range(0, 5) == 0);
    r.hit      = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    r.victim   = 4'd1 << $urandom_range(0, 3);
    r.delay    = $urandom_range(0, 3);
    r.rst_beat = -1;
    return r;
  endfunction

  function automatic req_t mk(bit is_op, logic [1:0] op, logic [31:0] addr, bit wr, bit suc,
                              logic [3:0] h, logic [3:0] v, int delay, int rst_beat);
    req_t r;
    r.is_op = is_op; r.op = op; r.addr = addr; r.wr = wr; r.suc = suc;
    r.hit = h; r.victim = v; r.delay = delay; r.rst_beat = rst_beat;
    return r;
  endfunction

  // Decide on the next request and present it on the pipeline side this cycle.
  task automatic applyStimulus(input bit allow_idle);
    if (directed.size() > 0) begin
      nxt     = directed.pop_front();
      offered = 1'b1;
    end else begin
      nxt     = rand_req();
      offered = allow_idle ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    valid  = offered;
    opflag = offered & nxt.is_op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    valid = 1'b0; opflag = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
  endtask

  task automatic load_rbuf(input req_t r);
    rbuf_opcode      = $urandom;
    rbuf_opcode[4:3] = r.op;
    rbuf_addr        = r.addr;
    rbuf_type        = r.wr;
    rbuf_suc         = r.suc;
    hit              = r.hit;
    victim           = r.victim;
  endtask

  task automatic check_perf(input string tag);
    checkOutput({tag, "_perf_hit"},  perf_hit,  PERF ? exp_hits   : 0);
    checkOutput({tag, "_perf_miss"}, perf_miss, PERF ? exp_misses : 0);
  endtask

  task automatic idle_phase();
    int tries = 0;
    do begin
      applyStimulus(tries < 6);
      #1;
      checkOutput("idle_ready", ready, 1);
      checkOutput("idle_rbuf_we", rbuf_we, 1);
      checkOutput("idle_mem_req", mem_req, 0);
      step();
      tries++;
    end while (!offered);
  endtask

  task automatic run_txn();
    logic [3:0] hoh;
    int         hidx, beats, gap;
    bit         anyh, miss, aborted;
    logic [3:0] unv_l, exp_init, exp_unv, exp_we;
    hoh     = cur.hit & (~cur.hit + 4'd1);
    hidx    = 0;
    for (int i = 0; i < 4; i++) if (hoh[i]) hidx = i;
    anyh    = (cur.hit != 4'd0);
    miss    = !anyh || cur.suc;
    unv_l   = (cur.suc && anyh) ? hoh : 4'd0;
    aborted = 1'b0;
    offered = 1'b0;

    if (cur.is_op) begin
      applyStimulus(1);
      #1;
      exp_init = (cur.op == 2'd0) ? (4'd1 << cur.addr[1:0]) : 4'd0;
      exp_unv  = (cur.op == 2'd1) ? (4'd1 << cur.addr[1:0]) : (cur.op == 2'd2) ? hoh : 4'd0;
      checkOutput("op_ack", ack_op, 1);
      checkOutput("op_ready", ready, 1);
      checkOutput("op_tagv_init", tagv_init, exp_init);
      checkOutput("op_tagv_unvalid", tagv_unvalid, exp_unv);
      checkOutput("op_data_we", data_we, 0);
      checkOutput("op_mem_req", mem_req, 0);
      step();
    end else begin
      check_perf("lookup");
      if (cur.wr) begin
        addr_ok = (cur.delay == 0);
        if (cur.delay == 0) applyStimulus(1);
        #1;
        exp_we = miss ? 4'd0 : hoh;
        checkOutput("wr_req", {mem_req, mem_wr}, 2'b11);
        checkOutput("wr_data_we", data_we, exp_we);
        checkOutput("wr_tagv_we", tagv_we, exp_we);
        checkOutput("wr_use", use_o, exp_we);
        checkOutput("wr_unvalid", tagv_unvalid, unv_l);
        checkOutput("wr_ready", ready, cur.delay == 0);
        checkOutput("wr_stall", stall, cur.delay != 0);
        step();
        for (int d = 1; d <= cur.delay; d++) begin
          addr_ok = (d == cur.delay);
          if (d == cur.delay) applyStimulus(1);
          #1;
          checkOutput("wrwait_req", {mem_req, mem_wr}, 2'b11);
          checkOutput("wrwait_ready", ready, d == cur.delay);
          checkOutput("wrwait_data_we", data_we, 0);
          step();
        end
      end else if (!miss) begin
        applyStimulus(1);
        #1;
        checkOutput("rdhit_choose_way", choose_way, hidx);
        checkOutput("rdhit_use", use_o, hoh);
        checkOutput("rdhit_ready", ready, 1);
        checkOutput("rdhit_mem_req", mem_req, 0);
        checkOutput("rdhit_data_we", data_we, 0);
        step();
      end else begin
        addr_ok = (cur.delay == 0);
        #1;
        checkOutput("miss_req", {mem_req, mem_wr}, 2'b10);
        checkOutput("miss_ready", ready, 0);
        checkOutput("miss_unvalid", tagv_unvalid, unv_l);
        checkOutput("miss_use", use_o, 0);
        checkOutput("miss_data_we", data_we, 0);
        step();
        for (int d = 1; d <= cur.delay; d++) begin
          addr_ok = (d == cur.delay);
          #1;
          checkOutput("rdreq_req", {mem_req, mem_wr}, 2'b10);
          checkOutput("rdreq_ready", ready, 0);
          step();
        end
        beats = cur.suc ? 1 : 4;
        for (int b = 0; b < beats && !aborted; b++) begin
          gap = $urandom_range(0, 2);
          for (int g = 0; g < gap; g++) begin
            addr_ok = $urandom_range(0, 1);
            #1;
            checkOutput("gap_beat", refill_beat, b);
            checkOutput("gap_replace", data_replace, 0);
            checkOutput("gap_data_we", data_we, 0);
            checkOutput("gap_req", {mem_req, ready}, 2'b10);
            step();
          end
          if (b == cur.rst_beat) begin
            rstn = 1'b0;
            #1;
            exp_hits = 0; exp_misses = 0;
            checkOutput("rst_ready", ready, 1);
            checkOutput("rst_rbuf_we", rbuf_we, 1);
            checkOutput("rst_mem_req", mem_req, 0);
            checkOutput("rst_refill_beat", refill_beat, 0);
            check_perf("rst");
            step();
            rstn    = 1'b1;
            aborted = 1'b1;
          end else begin
            data_ok = 1'b1;
            addr_ok = $urandom_range(0, 1);
            #1;
            exp_we = cur.suc ? 4'd0 : cur.victim;
            checkOutput("beat_idx", refill_beat, b);
            checkOutput("beat_replace", data_replace, 1);
            checkOutput("beat_data_we", data_we, exp_we);
            checkOutput("beat_tagv_we", tagv_we, exp_we);
            checkOutput("beat_choose_return", choose_return, cur.suc || (b == cur.addr[3:2]));
            checkOutput("beat_use", use_o, (b == beats - 1 && !cur.suc) ? cur.victim : 4'd0);
            checkOutput("beat_ready", ready, 0);
            step();
          end
        end
        if (!aborted) begin
          applyStimulus(1);
          #1;
          checkOutput("done_ready", ready, 1);
          checkOutput("done_mem_req", mem_req, 0);
          checkOutput("done_data_we", data_we, 0);
          step();
        end
      end
      if (!aborted) begin
        if (!miss) exp_hits++;
        if (!anyh && !cur.suc) exp_misses++;
      end
    end
    need_idle = aborted || !offered;
  endtask

  initial begin
    rstn = 1'b0; valid = 1'b0; opflag = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    rbuf_opcode = '0; rbuf_addr = '0; rbuf_type = 1'b0; rbuf_suc = 1'b0;
    hit = '0; victim = 4'd1;

    directed.push_back(mk(0, 0, 32'h0,  0, 0, 4'b0100, 4'b0001, 0, -1));
    directed.push_back(mk(0, 0, 32'h4,  0, 0, 4'b0100, 4'b0001, 0, -1));
    directed.push_back(mk(0, 0, 32'h8,  0, 0, 4'b0000, 4'b1000, 3, -1));
    directed.push_back(mk(0, 0, 32'h10, 0, 1, 4'b0010, 4'b0100, 0, -1));
    directed.push_back(mk(0, 0, 32'h20, 1, 0, 4'b0001, 4'b0010, 2, -1));
    directed.push_back(mk(1, 1, 32'h3,  0, 0, 4'b0000, 4'b0001, 0, -1));
    directed.push_back(mk(0, 0, 32'h4,  0, 0, 4'b0000, 4'b0010, 1, 2));

    #3;
    checkOutput("reset_ready", ready, 1);
    checkOutput("reset_rbuf_we", rbuf_we, 1);
    checkOutput("reset_mem_req", mem_req, 0);
    checkOutput("reset_refill_beat", refill_beat, 0);
    check_perf("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;

    need_idle = 1'b1;
    for (int t = 0; t < 80; t++) begin
      if (need_idle) idle_phase();
      cur = nxt;
      load_rbuf(cur);
      run_txn();
    end
    check_perf("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
